axis_pkt_arbiter: RTL and testbench

- Packet-level round-robin arbiter that shares the single AXI-Stream FIFO write port among NUM_SRC requesters.
- Sits directly in front of the FIFO top-level input.
- Grants one source for a whole packet and locks until tlast is accepted, so packets never interleave in the FIFO.
- Guards against runaway packets with a beat-length limit and a sticky error flag.

---
 rtl/axis_pkg.sv | 30 +++
 rtl/rr_pick.sv | 29 ++
 rtl/axis_pkt_arbiter.sv | 131 +++++++++++++
 tb/tb_axis_pkt_arbiter.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_pkg.sv
// Shared types and helpers for the AXI-Stream packet arbiter.
//   arb_state_e : arbiter FSM state encoding
//   rr_next()   : round-robin search, first requester after 'last' (mod n)
package axis_pkg;

   localparam int MAX_SRC = 4;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } arb_state_e;

   // Walks the offsets from the farthest to the nearest so the nearest
   // requester after 'last' is the one left in 'pick'. With no request the
   // previous grant is returned unchanged.
   function automatic int rr_next(input logic [MAX_SRC-1:0] req,
                                  input int                 last,
                                  input int                 n);
      int idx;
      int pick;
      pick = last;
      for (int k = MAX_SRC; k >= 1; k--) begin
         idx = last + k;
         if (idx >= n) idx = idx - n;
         if ((k <= n) && req[idx[1:0]]) pick = idx;
      end
      return pick;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin priority picker.
//   req     : request vector, one bit per source
//   last    : index of the most recently served source
//   grant   : next source to serve (first requester after 'last')
//   any_req : at least one request present
module rr_pick
   import axis_pkg::*;
#(
   parameter int N  = 2,
   parameter int IW = 1
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] last,
   output logic [IW-1:0] grant,
   output logic          any_req
);

   logic [MAX_SRC-1:0] req_ext;
   int                 pick;

   always_comb begin
      req_ext        = '0;
      req_ext[N-1:0] = req;
      pick           = rr_next(req_ext, int'(last), N);
      grant          = IW'(pick);
      any_req        = |req;
   end

endmodule

// File: rtl/axis_pkt_arbiter.sv
// Packet-level round-robin arbiter sharing one AXI-Stream FIFO write port.
// A source keeps the grant for a whole packet; a packet longer than
// MAX_PKT_LEN beats gets a forced tlast and raises the sticky len_err.
//   clk, reset_n         : clock, async active-low reset
//   s_tdata/tvalid/tlast : per-source streams (source i at [i*DATA_W +: DATA_W])
//   s_tready             : per-source ready, only the granted source sees m_tready
//   m_tdata/tvalid/tlast : to FIFO input; m_tready from FIFO
//   fifo_w_en            : FIFO write enable, same as m_tvalid
//   grant_id, busy       : current owner of the port, valid while busy
//   len_err, len_err_clr : sticky forced-tlast flag and its synchronous clear
//
// state | meaning
// IDLE  | no packet locked; arbitrate among valid sources (one cycle)
// BUSY  | grant_id owns the port until a beat with m_tlast is accepted
module axis_pkt_arbiter
   import axis_pkg::*;
#(
   parameter  int NUM_SRC     = 2,
   parameter  int DATA_W      = 8,
   parameter  int MAX_PKT_LEN = 256,
   localparam int GW          = $clog2(NUM_SRC),
   localparam int CW          = $clog2(MAX_PKT_LEN)
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic [NUM_SRC*DATA_W-1:0] s_tdata,
   input  logic [NUM_SRC-1:0]        s_tvalid,
   input  logic [NUM_SRC-1:0]        s_tlast,
   output logic [NUM_SRC-1:0]        s_tready,
   output logic [DATA_W-1:0]         m_tdata,
   output logic                      m_tvalid,
   output logic                      m_tlast,
   input  logic                      m_tready,
   output logic                      fifo_w_en,
   output logic [GW-1:0]             grant_id,
   output logic                      busy,
   output logic                      len_err,
   input  logic                      len_err_clr
);

   localparam logic [CW-1:0] LEN_RELOAD = CW'(MAX_PKT_LEN - 1);

   arb_state_e    state_q, state_d;
   logic [GW-1:0] grant_q, grant_d;
   logic [GW-1:0] last_grant_q, last_grant_d;
   logic [CW-1:0] beats_left_q, beats_left_d;
   logic          len_err_q, len_err_d;
   logic [GW-1:0] pick_idx;
   logic          any_req;
   logic          beat_ok;
   logic          len_set;

   rr_pick #(
      .N  (NUM_SRC),
      .IW (GW)
   ) u_rr_pick (
      .req     (s_tvalid),
      .last    (last_grant_q),
      .grant   (pick_idx),
      .any_req (any_req)
   );

   // Outputs depend only on state_q, so reset forces them to zero at once.
   // beats_left counts down; reaching zero marks the last allowed beat.
   always_comb begin : datapath
      s_tready = '0;
      m_tdata  = '0;
      m_tvalid = 1'b0;
      m_tlast  = 1'b0;
      if (state_q == BUSY) begin
         m_tdata           = s_tdata[int'(grant_q)*DATA_W +: DATA_W];
         m_tvalid          = s_tvalid[grant_q];
         m_tlast           = s_tlast[grant_q] | (beats_left_q == '0);
         s_tready[grant_q] = m_tready;
      end
   end

   always_comb begin : next_state
      state_d      = state_q;
      grant_d      = grant_q;
      last_grant_d = last_grant_q;
      beats_left_d = beats_left_q;
      len_set      = 1'b0;
      beat_ok      = m_tvalid & m_tready;
      case (state_q)
         IDLE: begin
            if (any_req) begin
               grant_d = pick_idx;
               state_d = BUSY;
            end
         end
         BUSY: begin
            if (beat_ok) begin
               if (m_tlast) begin
                  state_d      = IDLE;
                  last_grant_d = grant_q;
                  beats_left_d = LEN_RELOAD;
                  // tlast came from the length limit, not from the source
                  len_set      = ~s_tlast[grant_q];
               end else begin
                  beats_left_d = beats_left_q - CW'(1);
               end
            end
         end
         default: state_d = IDLE;
      endcase
      len_err_d = len_set | (len_err_q & ~len_err_clr);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= IDLE;
         grant_q      <= '0;
         last_grant_q <= GW'(NUM_SRC - 1);
         beats_left_q <= LEN_RELOAD;
         len_err_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         last_grant_q <= last_grant_d;
         beats_left_q <= beats_left_d;
         len_err_q    <= len_err_d;
      end
   end

   assign fifo_w_en = m_tvalid;
   assign grant_id  = grant_q;
   assign busy      = (state_q == BUSY);
   assign len_err   = len_err_q;

endmodule

// File: tb/tb_axis_pkt_arbiter.sv
module tb_axis_pkt_arbiter;

   localparam int NS = 2;
   localparam int DW = 8;
   localparam int ML = 4;

   typedef struct packed {
      logic [7:0] d;
      logic       l;
   } beat_t;

   typedef struct {
      logic [9:0] v;
      int         cyc;
   } mon_t;

   logic             clk = 1'b0;
   logic             reset_n;
   logic [NS*DW-1:0] s_tdata;
   logic [NS-1:0]    s_tvalid;
   logic [NS-1:0]    s_tlast;
   logic [NS-1:0]    s_tready;
   logic [DW-1:0]    m_tdata;
   logic             m_tvalid;
   logic             m_tlast;
   logic             m_tready;
   logic             fifo_w_en;
   logic             grant_id;
   logic             busy;
   logic             len_err;
   logic             len_err_clr;

   int         checks   = 0;
   int         failures = 0;
   int         cyc      = 0;
   beat_t      sq[2][$];
   logic [9:0] ex[2][$];
   mon_t       got[$];
   logic [9:0] exp_q[$];

   axis_pkt_arbiter #(
      .NUM_SRC     (NS),
      .DATA_W      (DW),
      .MAX_PKT_LEN (ML)
   ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .s_tdata     (s_tdata),
      .s_tvalid    (s_tvalid),
      .s_tlast     (s_tlast),
      .s_tready    (s_tready),
      .m_tdata     (m_tdata),
      .m_tvalid    (m_tvalid),
      .m_tlast     (m_tlast),
      .m_tready    (m_tready),
      .fifo_w_en   (fifo_w_en),
      .grant_id    (grant_id),
      .busy        (busy),
      .len_err     (len_err),
      .len_err_clr (len_err_clr)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // FIFO side: every accepted beat with its source and cycle
   always @(negedge clk) begin
      if (reset_n === 1'b1 && m_tvalid === 1'b1 && m_tready === 1'b1)
         got.push_back('{v: {grant_id, m_tlast, m_tdata}, cyc: cyc});
   end

   initial begin
      #500000;
      $display("FAIL watchdog: observed=no finish expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   function automatic logic [9:0] ev(input int s, input logic l, input logic [7:0] d);
      logic sb;
      sb = s[0];
      return {sb, l, d};
   endfunction

   task automatic apply(input logic rdy);
      for (int i = 0; i < NS; i++) begin
         if (sq[i].size() > 0) begin
            s_tvalid[i]          = 1'b1;
            s_tdata[i*DW +: DW]  = sq[i][0].d;
            s_tlast[i]           = sq[i][0].l;
         end else begin
            s_tvalid[i]          = 1'b0;
            s_tdata[i*DW +: DW]  = '0;
            s_tlast[i]           = 1'b0;
         end
      end
      m_tready = rdy;
   endtask

   // Called at the negedge: record handshakes, then advance to the next cycle.
   task automatic finish_cycle();
      logic [NS-1:0] fire;
      logic [NS-1:0] gmask;
      fire  = s_tvalid & s_tready;
      gmask = (busy === 1'b1) ? (2'b01 << grant_id) : 2'b00;
      chk("stray_tready", 32'(s_tready & ~gmask), 0);
      @(posedge clk);
      #1;
      for (int i = 0; i < NS; i++)
         if (fire[i]) void'(sq[i].pop_front());
      apply(m_tready);
   endtask

   task automatic step(input logic rdy);
      apply(rdy);
      @(negedge clk);
      finish_cycle();
   endtask

   task automatic drain(input bit rnd, input int budget);
      int n;
      n = 0;
      while ((sq[0].size() > 0 || sq[1].size() > 0 || busy === 1'b1) && n < budget) begin
         step(rnd ? logic'($urandom_range(0, 3) != 0) : 1'b1);
         n++;
      end
      chk("drain_left", 32'(sq[0].size() + sq[1].size()), 0);
   endtask

   task automatic chk_seq(input string tag, input logic [9:0] e[$]);
      chk({tag, "_count"}, 32'(got.size()), 32'(e.size()));
      foreach (e[i])
         if (i < got.size()) chk({tag, "_beat"}, 32'(got[i].v), 32'(e[i]));
   endtask

   task automatic do_reset();
      reset_n     = 1'b0;
      s_tvalid    = '0;
      s_tdata     = '0;
      s_tlast     = '0;
      m_tready    = 1'b0;
      len_err_clr = 1'b0;
      sq[0].delete();
      sq[1].delete();
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;
      got.delete();
   endtask

   initial begin
      int   c0;
      int   n;
      int   last;
      int   s;
      int   npk;
      int   len;
      logic lst;
      logic forced;
      logic [7:0] d;
      logic [9:0] v;

      // 1: reset values and a single 3-beat packet from src0
      do_reset();
      chk("rst_busy", 32'(busy), 0);
      chk("rst_grant", 32'(grant_id), 0);
      chk("rst_m_tvalid", 32'(m_tvalid), 0);
      chk("rst_m_tlast", 32'(m_tlast), 0);
      chk("rst_m_tdata", 32'(m_tdata), 0);
      chk("rst_w_en", 32'(fifo_w_en), 0);
      chk("rst_s_tready", 32'(s_tready), 0);
      chk("rst_len_err", 32'(len_err), 0);
      sq[0] = '{'{8'h11, 1'b0}, '{8'h12, 1'b0}, '{8'h13, 1'b1}};
      c0 = cyc;
      step(1'b1);
      chk("t1_busy", 32'(busy), 1);
      chk("t1_grant", 32'(grant_id), 0);
      repeat (3) step(1'b1);
      chk("t1_busy_drop", 32'(busy), 0);
      exp_q = '{ev(0, 1'b0, 8'h11), ev(0, 1'b0, 8'h12), ev(0, 1'b1, 8'h13)};
      chk_seq("t1", exp_q);
      if (got.size() > 0) chk("t1_latency", 32'(got[0].cyc - c0), 1);

      // 2: both sources continuously valid, alternating 2-beat packets
      do_reset();
      sq[0] = '{'{8'hA0, 1'b0}, '{8'hA1, 1'b1}, '{8'hA0, 1'b0}, '{8'hA1, 1'b1}};
      sq[1] = '{'{8'hB0, 1'b0}, '{8'hB1, 1'b1}};
      c0 = cyc;
      drain(1'b0, 40);
      exp_q = '{ev(0, 1'b0, 8'hA0), ev(0, 1'b1, 8'hA1), ev(1, 1'b0, 8'hB0),
                ev(1, 1'b1, 8'hB1), ev(0, 1'b0, 8'hA0), ev(0, 1'b1, 8'hA1)};
      chk_seq("t2", exp_q);
      if (got.size() >= 6) begin
         chk("t2_latency", 32'(got[0].cyc - c0), 1);
         chk("t2_gap1", 32'(got[2].cyc - got[1].cyc), 2);
         chk("t2_gap2", 32'(got[4].cyc - got[3].cyc), 2);
         chk("t2_inner", 32'(got[3].cyc - got[2].cyc), 1);
      end

      // 3: back-pressure for 10 cycles inside a src1 packet
      got.delete();
      sq[1] = '{'{8'hC0, 1'b0}, '{8'hC1, 1'b0}, '{8'hC2, 1'b1}};
      step(1'b1);
      step(1'b1);
      for (int i = 0; i < 10; i++) begin
         apply(1'b0);
         @(negedge clk);
         chk("t3_stall_data", 32'(m_tdata), 32'h C1);
         chk("t3_stall_valid", 32'(m_tvalid), 1);
         chk("t3_stall_w_en", 32'(fifo_w_en), 1);
         chk("t3_stall_tready", 32'(s_tready), 0);
         chk("t3_stall_grant", 32'(grant_id), 1);
         finish_cycle();
      end
      drain(1'b0, 20);
      exp_q = '{ev(1, 1'b0, 8'hC0), ev(1, 1'b0, 8'hC1), ev(1, 1'b1, 8'hC2)};
      chk_seq("t3", exp_q);

      // 4: over-long packet from src0 with src1 pending
      do_reset();
      sq[0] = '{'{8'h01, 1'b0}, '{8'h02, 1'b0}, '{8'h03, 1'b0},
                '{8'h04, 1'b0}, '{8'h05, 1'b0}, '{8'h06, 1'b1}};
      sq[1] = '{'{8'h21, 1'b0}, '{8'h22, 1'b1}};
      drain(1'b0, 40);
      exp_q = '{ev(0, 1'b0, 8'h01), ev(0, 1'b0, 8'h02), ev(0, 1'b0, 8'h03),
                ev(0, 1'b1, 8'h04), ev(1, 1'b0, 8'h21), ev(1, 1'b1, 8'h22),
                ev(0, 1'b0, 8'h05), ev(0, 1'b1, 8'h06)};
      chk_seq("t4", exp_q);
      chk("t4_len_err_set", 32'(len_err), 1);
      len_err_clr = 1'b1;
      step(1'b1);
      len_err_clr = 1'b0;
      chk("t4_len_err_clr", 32'(len_err), 0);

      // 4b: set and clear in the same cycle, set wins
      got.delete();
      sq[0] = '{'{8'h31, 1'b0}, '{8'h32, 1'b0}, '{8'h33, 1'b0}, '{8'h34, 1'b0}};
      len_err_clr = 1'b1;
      n = 0;
      while (sq[0].size() > 0 && n < 20) begin
         step(1'b1);
         n++;
      end
      chk("t4b_set_wins", 32'(len_err), 1);
      step(1'b1);
      chk("t4b_clear_after", 32'(len_err), 0);
      len_err_clr = 1'b0;
      exp_q = '{ev(0, 1'b0, 8'h31), ev(0, 1'b0, 8'h32), ev(0, 1'b0, 8'h33), ev(0, 1'b1, 8'h34)};
      chk_seq("t4b", exp_q);

      // 5: asynchronous reset in the middle of a packet
      do_reset();
      sq[0] = '{'{8'h41, 1'b0}, '{8'h42, 1'b0}, '{8'h43, 1'b0}, '{8'h44, 1'b0}, '{8'h45, 1'b1}};
      n = 0;
      while (got.size() < 2 && n < 10) begin
         step(1'b1);
         n++;
      end
      chk("t5_beats_before", 32'(got.size()), 2);
      #2 reset_n = 1'b0;
      #1;
      chk("t5_m_tvalid", 32'(m_tvalid), 0);
      chk("t5_m_tdata", 32'(m_tdata), 0);
      chk("t5_m_tlast", 32'(m_tlast), 0);
      chk("t5_w_en", 32'(fifo_w_en), 0);
      chk("t5_s_tready", 32'(s_tready), 0);
      chk("t5_busy", 32'(busy), 0);
      chk("t5_grant", 32'(grant_id), 0);
      sq[0].delete();
      apply(1'b1);
      @(posedge clk);
      #1 reset_n = 1'b1;
      got.delete();
      sq[1] = '{'{8'h51, 1'b1}};
      drain(1'b0, 20);
      sq[0] = '{'{8'h61, 1'b1}};
      sq[1] = '{'{8'h71, 1'b1}};
      drain(1'b0, 20);
      exp_q = '{ev(1, 1'b1, 8'h51), ev(0, 1'b1, 8'h61), ev(1, 1'b1, 8'h71)};
      chk_seq("t5", exp_q);

      // 6: src1 alone, three packets back to back
      got.delete();
      sq[1] = '{'{8'h81, 1'b0}, '{8'h82, 1'b1}, '{8'h83, 1'b0},
                '{8'h84, 1'b1}, '{8'h85, 1'b0}, '{8'h86, 1'b1}};
      drain(1'b0, 40);
      exp_q = '{ev(1, 1'b0, 8'h81), ev(1, 1'b1, 8'h82), ev(1, 1'b0, 8'h83),
                ev(1, 1'b1, 8'h84), ev(1, 1'b0, 8'h85), ev(1, 1'b1, 8'h86)};
      chk_seq("t6", exp_q);
      if (got.size() >= 6) begin
         chk("t6_gap1", 32'(got[2].cyc - got[1].cyc), 2);
         chk("t6_gap2", 32'(got[4].cyc - got[3].cyc), 2);
      end

      // Random: packet lists per source, random FIFO back-pressure.
      // Reference: packets cut into ML-beat pieces, served round-robin.
      for (int r = 0; r < 3; r++) begin
         do_reset();
         ex[0].delete();
         ex[1].delete();
         exp_q.delete();
         forced = 1'b0;
         for (int src = 0; src < NS; src++) begin
            npk = int'($urandom_range(2, 5));
            for (int p = 0; p < npk; p++) begin
               len = int'($urandom_range(1, 7));
               for (int b = 0; b < len; b++) begin
                  d   = 8'($urandom);
                  lst = (b == len - 1);
                  sq[src].push_back('{d, lst});
                  ex[src].push_back(ev(src, lst || ((b % ML) == ML - 1), d));
                  if (((b % ML) == ML - 1) && !lst) forced = 1'b1;
               end
            end
         end
         last = NS - 1;
         while (ex[0].size() > 0 || ex[1].size() > 0) begin
            s = (last + 1) % NS;
            if (ex[s].size() == 0) s = last;
            do begin
               v = ex[s].pop_front();
               exp_q.push_back(v);
            end while (!v[8] && ex[s].size() > 0);
            last = s;
         end
         drain(1'b1, 3000);
         chk_seq("rand", exp_q);
         chk("rand_len_err", 32'(len_err), 32'(forced));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
